// File: rtl/systolic_mm_engine.sv
// Output-stationary systolic matrix-multiply engine: C[ROWS][COLS] = A[ROWS][K] x B[K][COLS].
// Operands stream in one k-slice per beat (A column + B row), are skewed internally so that
// matching terms meet in PE(i,j), and results drain one C row per out_valid/out_ready handshake.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   start, k_len                 job start (sampled in IDLE) and inner dimension K
//   in_valid/in_ready, a_col, b_row   operand beat stream (A column k, B row k)
//   out_valid/out_ready, out_data, out_row   result row stream
//   busy, done                   job active; one-cycle completion pulse
module systolic_mm_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned K_MAX  = 256,
  localparam int unsigned K_W   = $clog2(K_MAX + 1),
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [K_W-1:0]          k_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*DATA_W-1:0]  a_col,
  input  logic [COLS*DATA_W-1:0]  b_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_data,
  output logic [ROW_W-1:0]        out_row,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned FC_W       = $clog2(ROWS + COLS + 1);
  localparam int unsigned FLUSH_LAST = ROWS + COLS - 2;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [K_W-1:0]         k_q, k_d, cnt_q, cnt_d;
  logic [FC_W-1:0]        fcnt_q, fcnt_d;
  logic [ROW_W-1:0]       row_q, row_d, load_row;
  logic                   in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic [COLS*ACC_W-1:0]  out_data_q, out_data_d;
  logic                   clr, acc_en, accept, load_out;

  logic signed [DATA_W-1:0] a_edge   [ROWS];
  logic signed [DATA_W-1:0] b_edge   [COLS];
  logic signed [DATA_W-1:0] a_east   [ROWS][COLS];
  logic signed [DATA_W-1:0] b_south  [ROWS][COLS];
  logic signed [ACC_W-1:0]  acc      [ROWS][COLS];

  assign accept = in_valid & in_ready_q;
  // Products only count while operands can still be in flight; DRAIN/IDLE keep results frozen.
  assign acc_en = (state_q == LOAD) || (state_q == FLUSH);

  // Controller: next state, counters and registered outputs.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    fcnt_d     = fcnt_q;
    row_d      = row_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    clr        = 1'b0;
    load_out   = 1'b0;
    load_row   = row_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k_len;
          cnt_d   = '0;
          fcnt_d  = '0;
          row_d   = '0;
          clr     = 1'b1;
          state_d = (k_len == K_W'(0)) ? FLUSH : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + K_W'(1);
          if (cnt_d == k_q) state_d = FLUSH;
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q + FC_W'(1);
        if (fcnt_q == FC_W'(FLUSH_LAST)) begin
          state_d  = DRAIN;
          row_d    = '0;
          load_out = 1'b1;
          load_row = '0;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (row_q == ROW_W'(ROWS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            row_d   = '0;
          end else begin
            row_d    = row_q + ROW_W'(1);
            load_out = 1'b1;
            load_row = row_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_out) begin
      for (int j = 0; j < COLS; j++) out_data_d[j*ACC_W +: ACC_W] = acc[load_row][j];
    end
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == DRAIN);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      fcnt_q      <= '0;
      row_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      fcnt_q      <= fcnt_d;
      row_q       <= row_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
    end
  end

  // A row i enters column 0 after i cycles of delay; bubbles inject zeros.
  for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
    logic signed [DATA_W-1:0] a_in;
    assign a_in = accept ? a_col[i*DATA_W +: DATA_W] : '0;
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_in;
    end else begin : g_dly
      logic signed [DATA_W-1:0] sr_q [i];
      logic signed [DATA_W-1:0] sr_d [i];
      always_comb begin
        sr_d[0] = clr ? '0 : a_in;
        for (int n = 1; n < i; n++) sr_d[n] = clr ? '0 : sr_q[n-1];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int n = 0; n < i; n++) sr_q[n] <= '0;
        end else begin
          for (int n = 0; n < i; n++) sr_q[n] <= sr_d[n];
        end
      end
      assign a_edge[i] = sr_q[i-1];
    end
  end

  // B column j enters row 0 after j cycles of delay; bubbles inject zeros.
  for (genvar j = 0; j < COLS; j++) begin : g_b_skew
    logic signed [DATA_W-1:0] b_in;
    assign b_in = accept ? b_row[j*DATA_W +: DATA_W] : '0;
    if (j == 0) begin : g_direct
      assign b_edge[j] = b_in;
    end else begin : g_dly
      logic signed [DATA_W-1:0] sr_q [j];
      logic signed [DATA_W-1:0] sr_d [j];
      always_comb begin
        sr_d[0] = clr ? '0 : b_in;
        for (int n = 1; n < j; n++) sr_d[n] = clr ? '0 : sr_q[n-1];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int n = 0; n < j; n++) sr_q[n] <= '0;
        end else begin
          for (int n = 0; n < j; n++) sr_q[n] <= sr_d[n];
        end
      end
      assign b_edge[j] = sr_q[j-1];
    end
  end

  // PE grid: forward A east / B south one cycle, accumulate the full-width signed product.
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_pe
      logic signed [DATA_W-1:0]   a_w, b_n, a_q, a_d, b_q, b_d;
      logic signed [ACC_W-1:0]    acc_q, acc_d;
      logic signed [2*DATA_W-1:0] prod;
      if (j == 0) begin : g_aw_edge
        assign a_w = a_edge[i];
      end else begin : g_aw_pe
        assign a_w = a_east[i][j-1];
      end
      if (i == 0) begin : g_bn_edge
        assign b_n = b_edge[j];
      end else begin : g_bn_pe
        assign b_n = b_south[i-1][j];
      end
      assign prod = (2*DATA_W)'(a_w) * (2*DATA_W)'(b_n);
      always_comb begin
        a_d   = clr ? '0 : a_w;
        b_d   = clr ? '0 : b_n;
        acc_d = acc_q;
        if (clr)         acc_d = '0;
        else if (acc_en) acc_d = acc_q + ACC_W'(prod);
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
        end
      end
      assign a_east[i][j]  = a_q;
      assign b_south[i][j] = b_q;
      assign acc[i][j]     = acc_q;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = row_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Bench for systolic_mm_engine: table of jobs with hand-computed C, run against a 40-bit and a
// 32-bit accumulator instance in lockstep, plus backpressure/start-ignore and mid-job reset sequences.
module tb_systolic_mm_engine;
  localparam int R = 4;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst, start, in_valid, out_ready;
  logic [8:0]   k_len;
  logic [63:0]  a_col, b_row;
  logic         in_ready, out_valid, busy, done;
  logic [159:0] out_data;
  logic [1:0]   out_row;
  logic         in_ready32, out_valid32, busy32, done32;
  logic [127:0] out_data32;
  logic [1:0]   out_row32;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int     k;
    int     a_base, a_id;          // A[i][k] = a_base + (i==k ? a_id : 0)
    int     b_base, b_km, b_jm;    // B[k][j] = b_base + b_km*k + b_jm*j
    bit     bubble;                // in_valid toggles 1,0,1,0 during LOAD
    longint c_base, c_rm, c_cm;    // expected C[i][j] = c_base + c_rm*i + c_cm*j
    bit     chk32;
    longint c32_base;              // expected C for the 32-bit accumulator instance
    int     exp_ov;                // cycle of first out_valid
    int     exp_ir;                // cycles with in_ready high
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  systolic_mm_engine #(.DATA_W(16), .ACC_W(40), .ROWS(R), .COLS(C), .K_MAX(256)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .busy(busy), .done(done));

  systolic_mm_engine #(.DATA_W(16), .ACC_W(32), .ROWS(R), .COLS(C), .K_MAX(256)) dut32 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid), .in_ready(in_ready32),
    .a_col(a_col), .b_row(b_row), .out_valid(out_valid32), .out_ready(out_ready),
    .out_data(out_data32), .out_row(out_row32), .busy(busy32), .done(done32));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_row(input string nm, input vec_t v, input int r);
    longint act;
    for (int j = 0; j < C; j++) begin
      act = longint'($signed(out_data[j*40 +: 40]));
      chk($sformatf("%s C[%0d][%0d]", nm, r, j), act, v.c_base + v.c_rm * r + v.c_cm * j);
      if (v.chk32) begin
        act = longint'($signed(out_data32[j*32 +: 32]));
        chk($sformatf("%s C32[%0d][%0d]", nm, r, j), act, v.c32_base);
      end
    end
  endtask

  task automatic drive_beat(input vec_t v, input int beat);
    for (int i = 0; i < R; i++) a_col[i*16 +: 16] = 16'(v.a_base + ((i == beat) ? v.a_id : 0));
    for (int j = 0; j < C; j++) b_row[j*16 +: 16] = 16'(v.b_base + v.b_km * beat + v.b_jm * j);
  endtask

  // One full job; cycle t is the clock edge following the sample taken at the preceding negedge.
  task automatic run_job(input vec_t v, input int hold_row, input int hold_cyc, input bit poke_start);
    int beat = 0, lt = 0, ir_cnt = 0, ir_first = -1, first_ov = -1;
    int rows_seen = 0, hold_cnt = 0, done_t = -1;
    @(negedge clk);
    start = 1'b1; k_len = 9'(v.k); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    for (int t = 1; t <= 600; t++) begin
      start = 1'b0;
      if (done) begin
        done_t = t;
        chk("busy_at_done", longint'(busy), 0);
        chk("out_valid_at_done", longint'(out_valid), 0);
        if (v.chk32) chk("done32", longint'(done32 & ~busy32), 1);
        break;
      end
      if (in_ready) begin
        ir_cnt++;
        if (ir_first < 0) ir_first = t;
        if (!v.bubble || (lt % 2 == 0)) begin
          in_valid = 1'b1;
          drive_beat(v, beat);
          beat++;
        end else begin
          in_valid = 1'b0;
          a_col = {$urandom(), $urandom()};
          b_row = {$urandom(), $urandom()};
        end
        lt++;
      end else begin
        in_valid = 1'b0; a_col = '0; b_row = '0;
      end
      out_ready = 1'b1;
      if (out_valid) begin
        if (first_ov < 0) begin
          first_ov = t;
          if (poke_start) begin start = 1'b1; k_len = 9'd5; end
        end
        if (int'(out_row) == hold_row && hold_cnt < hold_cyc) begin
          out_ready = 1'b0;
          check_row("held", v, hold_row);
          hold_cnt++;
        end else begin
          chk("out_row", longint'(out_row), rows_seen);
          if (v.chk32) begin
            chk("out_valid32", longint'(out_valid32), 1);
            chk("out_row32", longint'(out_row32), rows_seen);
          end
          check_row("drain", v, rows_seen);
          rows_seen++;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("done_seen", longint'(done_t >= 0), 1);
    chk("first_out_valid_cycle", first_ov, v.exp_ov);
    chk("done_cycle", done_t, v.exp_ov + R + hold_cyc);
    chk("in_ready_cycles", ir_cnt, v.exp_ir);
    if (v.k > 0) chk("in_ready_first", ir_first, 1);
    chk("rows_drained", rows_seen, R);
    @(negedge clk);
    chk("done_one_cycle", longint'(done), 0);
    chk("idle_after_done", longint'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " in_ready"}, longint'(in_ready), 0);
    chk({nm, " out_valid"}, longint'(out_valid), 0);
    chk({nm, " busy"}, longint'(busy), 0);
    chk({nm, " done"}, longint'(done), 0);
    chk({nm, " out_row"}, longint'(out_row), 0);
    chk({nm, " out_data_zero"}, longint'(out_data == '0), 1);
    chk({nm, " in_ready32"}, longint'(in_ready32), 0);
  endtask

  initial begin
    tbl[0] = '{k:4, a_base:0, a_id:1, b_base:0, b_km:10, b_jm:1, bubble:0,
               c_base:0, c_rm:10, c_cm:1, chk32:0, c32_base:0, exp_ov:12, exp_ir:4};
    tbl[1] = '{k:3, a_base:-3, a_id:0, b_base:7, b_km:0, b_jm:0, bubble:0,
               c_base:-63, c_rm:0, c_cm:0, chk32:1, c32_base:-63, exp_ov:11, exp_ir:3};
    tbl[2] = '{k:3, a_base:-3, a_id:0, b_base:7, b_km:0, b_jm:0, bubble:1,
               c_base:-63, c_rm:0, c_cm:0, chk32:1, c32_base:-63, exp_ov:13, exp_ir:5};
    tbl[3] = '{k:256, a_base:-32768, a_id:0, b_base:-32768, b_km:0, b_jm:0, bubble:0,
               c_base:longint'(1) << 38, c_rm:0, c_cm:0, chk32:1, c32_base:0, exp_ov:264, exp_ir:256};
    tbl[4] = '{k:0, a_base:0, a_id:0, b_base:0, b_km:0, b_jm:0, bubble:0,
               c_base:0, c_rm:0, c_cm:0, chk32:1, c32_base:0, exp_ov:8, exp_ir:0};
    tbl[5] = '{k:4, a_base:1, a_id:0, b_base:0, b_km:10, b_jm:1, bubble:0,
               c_base:60, c_rm:0, c_cm:4, chk32:0, c32_base:0, exp_ov:12, exp_ir:4};

    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a_col = '0; b_row = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    for (int n = 0; n < 6; n++) run_job(tbl[n], -1, 0, 1'b0);

    // Backpressure on row 2 with a start pulse during DRAIN, then a clean follow-up job.
    run_job(tbl[5], 2, 5, 1'b1);
    run_job(tbl[0], -1, 0, 1'b0);

    // Reset mid-LOAD after two accepted beats, then a fresh job.
    @(negedge clk);
    start = 1'b1; k_len = 9'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; drive_beat(tbl[5], 0);
    @(negedge clk);
    drive_beat(tbl[5], 1);
    @(posedge clk);
    #2 rst = 1'b1; in_valid = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    run_job(tbl[0], -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
- Self-sequencing output-stationary systolic matrix-multiply engine: computes C[ROWS][COLS] = A[ROWS][K] x B[K][COLS] for a runtime K.
- Generalises the fixed square MAC grid to rectangular ROWS x COLS with separate data and accumulator widths.
- Adds internal input skewing, a start/done controller, valid/ready input streaming with bubble tolerance, and row-serial result drain with backpressure.
- Sits between the operand fetch streamer and the result writeback buffer.

Parameters:
- DATA_W, 16, signed operand width.
- ACC_W, 40, signed accumulator/result width; must be >= 2*DATA_W.
- ROWS, 4, PE grid rows (A rows / C rows).
- COLS, 4, PE grid columns (B columns / C columns).
- K_MAX, 256, largest supported inner dimension; K_W = $clog2(K_MAX+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin job; sampled only in IDLE.
- k_len  in  K_W  inner dimension K, captured with start.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine accepts beat.
- a_col  in  ROWS*DATA_W  column k of A; row i at [i*DATA_W +: DATA_W].
- b_row  in  COLS*DATA_W  row k of B; column j at [j*DATA_W +: DATA_W].
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts row.
- out_data  out  COLS*ACC_W  C[out_row][j] at [j*ACC_W +: ACC_W].
- out_row  out  $clog2(ROWS)  row index of out_data (width at least 1).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after last row accepted.

Behaviour:
- Reset (async): state IDLE; all PE accumulators, operand pipes and skew registers zero; in_ready, out_valid, busy, done = 0; out_row = 0; out_data = 0.
- States: IDLE, LOAD, FLUSH, DRAIN.
- IDLE: on start, capture k_len, clear all accumulators and skew/pipe registers, then go to LOAD. If k_len == 0, go directly to FLUSH, producing an all-zero C.
- LOAD: in_ready = 1.
  - Beat accepted when in_valid & in_ready; beat counter increments.
  - After the K-th accepted beat, go to FLUSH on the same edge.
- Bubbles: in LOAD with in_valid = 0, zeros are injected at the array edges.
  - The array shifts every cycle regardless of input.
  - Bubbles delay completion but never change results.
- Skew: A row i is delayed i cycles before entering column 0; B column j is delayed j cycles before entering row 0.
- Each PE registers its operands east/south each cycle and performs acc <= acc + a*b.
  - Product is a full 2*DATA_W signed value, sign-extended to ACC_W.
  - Accumulation is two's-complement wrap at ACC_W; no saturation.
- FLUSH: in_ready = 0; lasts exactly ROWS+COLS-1 cycles, zeros injected, then go to DRAIN.
- DRAIN: out_valid = 1, out_row starts at 0, out_data = accumulator row out_row.
  - out_data and out_row are held stable while out_ready = 0.
  - On handshake, out_row increments.
  - Handshake on row ROWS-1: out_valid drops, done pulses high for exactly the next cycle, state returns to IDLE.
  - done and busy = 0 are simultaneous in that cycle.
- start while busy: ignored; k_len changes while busy: ignored.
- Latency, in_valid held high: start edge at cycle 0.
  - Beats accepted cycles 1..K.
  - First out_valid at cycle K+ROWS+COLS.
  - With out_ready held high, done at cycle K+ROWS+COLS+ROWS.
- rst asserted mid-job: immediate abort to the reset state; partial results discarded; no done pulse.
- in_ready is a function of state only, with no combinational path from in_valid. out_valid has no combinational path from out_ready.

Test Plan:
- 4x4, K=4, A = identity, B[k][j] = 10*k+j, in_valid/out_ready always high -> out_valid first at cycle 12; rows equal B rows; done at cycle 16; in_ready high exactly cycles 1..4.
- 4x4, K=3, all A = -3, all B = 7 -> every C element = -63 (sign-extended to 40 bits); toggle in_valid 1,0,1,0,... -> identical results, first out_valid delayed by the 2 bubble cycles.
- DATA_W=16, K=256, all operands -32768 -> every C = 2^38 = 0x40_0000_0000, no wrap; second job with ACC_W=32 override and the same data -> 0 (wrap check).
- k_len=0 with start -> in_ready never asserts; FLUSH lasts ROWS+COLS-1 cycles; 4 all-zero rows drain; done pulses.
- out_ready held low for 5 cycles on row 2 -> out_data/out_row=2 stable; start pulsed during DRAIN is ignored; next job's results are unpolluted by the previous job.
- rst asserted during LOAD after 2 of 4 beats -> all outputs 0 asynchronously; new job after release yields correct C with no residue.
